rvfi_dii_seq: RTL and testbench

RVFI_DII_SEQ -- requirements
Module: rvfi_dii_seq

---
 rtl/rvfi_dii_seq.sv | 94 +++++++++
 tb/tb_rvfi_dii_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_dii_seq.sv
// rvfi_dii_seq: sequences DII commands into a core one at a time and emits RVFI-style execution packets.
module rvfi_dii_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_type,
  input  logic [31:0] cmd_instr,
  output logic        core_instr_valid,
  output logic [31:0] core_instr,
  input  logic        core_instr_ready,
  input  logic        retire_valid,
  input  logic        retire_trap,
  input  logic        retire_intr,
  output logic        core_rst_n,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [63:0] pkt_order,
  output logic        pkt_trap,
  output logic        pkt_halt,
  output logic        seq_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_RET = 3'd2, CORE_RST = 3'd3, HALT_PKT = 3'd4;
  logic [2:0] state;
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [63:0] order;
  logic full, empty, push, pop, start, eot;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = rst_n && !full;
  assign push = cmd_valid && cmd_ready;
  assign eot = mem[rp[AW-1:0]][32];
  assign start = state == IDLE && !empty && !pkt_valid;
  // end-of-trace is consumed on entry to CORE_RST, instructions on the core handshake
  assign pop = (start && eot) || (state == ISSUE && core_instr_ready);
  assign core_instr_valid = rst_n && state == ISSUE;
  assign core_instr = core_instr_valid ? mem[rp[AW-1:0]][31:0] : '0;
  assign core_rst_n = rst_n && state != CORE_RST;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= {cmd_type, cmd_instr};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      order <= '0;
      cnt <= '0;
      pkt_valid <= 1'b0;
      pkt_order <= '0;
      pkt_trap <= 1'b0;
      pkt_halt <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;
      if ((retire_valid && state != WAIT_RET) || (core_instr_ready && state == CORE_RST)) seq_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= eot ? CORE_RST : ISSUE;
          cnt <= CW'(RST_CYCLES - 1);
        end
        ISSUE: if (core_instr_ready) state <= WAIT_RET;
        WAIT_RET: if (retire_valid) begin
          state <= IDLE;
          pkt_valid <= 1'b1;
          pkt_trap <= retire_trap | retire_intr;
          pkt_halt <= 1'b0;
          pkt_order <= (retire_trap | retire_intr) ? order : order + 64'd1;
          if (!(retire_trap | retire_intr)) order <= order + 64'd1;
        end
        CORE_RST: begin
          order <= '0;
          if (cnt == '0) begin
            state <= HALT_PKT;
            pkt_valid <= 1'b1;
            pkt_halt <= 1'b1;
            pkt_trap <= 1'b0;
            pkt_order <= '0;
          end else cnt <= cnt - 1'b1;
        end
        HALT_PKT: if (pkt_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rvfi_dii_seq.sv
// tb_rvfi_dii_seq: directed checks of the DII sequencer with hand-computed packet expectations.
module tb_rvfi_dii_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_type = 1'b0;
  logic [31:0] cmd_instr = '0;
  logic core_instr_ready = 1'b0, retire_valid = 1'b0, retire_trap = 1'b0, retire_intr = 1'b0, pkt_ready = 1'b0;
  logic cmd_ready, core_instr_valid, core_rst_n, pkt_valid, pkt_trap, pkt_halt, seq_err;
  logic [31:0] core_instr;
  logic [63:0] pkt_order;
  int pass_n = 0, total_n = 0;
  always #5 clk = ~clk;
  rvfi_dii_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_instr(cmd_instr), .core_instr_valid(core_instr_valid), .core_instr(core_instr),
    .core_instr_ready(core_instr_ready), .retire_valid(retire_valid), .retire_trap(retire_trap),
    .retire_intr(retire_intr), .core_rst_n(core_rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_order(pkt_order), .pkt_trap(pkt_trap), .pkt_halt(pkt_halt), .seq_err(seq_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic t, input logic [31:0] ins);
    cmd_type = t;
    cmd_instr = ins;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) step;
    check("push_ready", cmd_ready, 1);
    step;
    cmd_valid = 1'b0;
  endtask
  task automatic do_instr(input logic [31:0] ins, input logic trap, input logic intr, input logic [63:0] ord, input int hold);
    for (int i = 0; i < 20 && !core_instr_valid; i++) step;
    check("issue_valid", core_instr_valid, 1);
    check("issue_instr", core_instr, ins);
    core_instr_ready = 1'b1;
    step;
    core_instr_ready = 1'b0;
    check("in_flight", core_instr_valid, 0);
    retire_valid = 1'b1;
    retire_trap = trap;
    retire_intr = intr;
    step;
    retire_valid = 1'b0;
    retire_trap = 1'b0;
    retire_intr = 1'b0;
    check("pkt_valid", pkt_valid, 1);
    check("pkt_order", pkt_order, ord);
    check("pkt_trap", pkt_trap, trap | intr);
    check("pkt_halt", pkt_halt, 0);
    for (int i = 0; i < hold; i++) begin
      step;
      check("hold_valid", pkt_valid, 1);
      check("hold_order", pkt_order, ord);
      check("hold_trap", pkt_trap, trap | intr);
      check("hold_no_issue", core_instr_valid, 0);
    end
    pkt_ready = 1'b1;
    step;
    pkt_ready = 1'b0;
    check("pkt_clear", pkt_valid, 0);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    step;
    step;
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_issue", core_instr_valid, 0);
    check("rst_instr", core_instr, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_seq_err", seq_err, 0);
    rst_n = 1'b1;
    step;
    check("run_core_rst_n", core_rst_n, 1);
    check("run_cmd_ready", cmd_ready, 1);
    // three plain instructions
    for (int i = 0; i < 3; i++) push(1'b0, 32'h13);
    for (int i = 1; i <= 3; i++) do_instr(32'h13, 1'b0, 1'b0, 64'(i), 0);
    // trapping and interrupted retirements do not advance order
    do_reset;
    push(1'b0, 32'h73);
    push(1'b0, 32'h13);
    push(1'b0, 32'h23);
    do_instr(32'h73, 1'b1, 1'b0, 0, 0);
    do_instr(32'h13, 1'b0, 1'b0, 1, 0);
    do_instr(32'h23, 1'b0, 1'b1, 1, 0);
    // FIFO full with the core stalled
    do_reset;
    cmd_type = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", cmd_ready, 1);
      cmd_instr = 32'(i + 1);
      step;
    end
    check("full_ready", cmd_ready, 0);
    cmd_instr = 32'd5;
    step;
    step;
    check("full_stall_ready", cmd_ready, 0);
    check("full_head", core_instr, 1);
    core_instr_ready = 1'b1;
    step;
    core_instr_ready = 1'b0;
    check("pop_no_push_ready", cmd_ready, 1);
    step;
    cmd_valid = 1'b0;
    check("refill_ready", cmd_ready, 0);
    retire_valid = 1'b1;
    step;
    retire_valid = 1'b0;
    check("full_pkt_order", pkt_order, 1);
    pkt_ready = 1'b1;
    step;
    pkt_ready = 1'b0;
    for (int i = 2; i <= 5; i++) do_instr(32'(i), 1'b0, 1'b0, 64'(i), 0);
    // end-of-trace
    do_reset;
    push(1'b0, 32'h13);
    push(1'b0, 32'h13);
    push(1'b1, 32'h0);
    do_instr(32'h13, 1'b0, 1'b0, 1, 0);
    do_instr(32'h13, 1'b0, 1'b0, 2, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (!core_rst_n) n++;
      if (pkt_valid) break;
    end
    check("core_rst_cycles", n, 4);
    check("halt_valid", pkt_valid, 1);
    check("halt_flag", pkt_halt, 1);
    check("halt_order", pkt_order, 0);
    check("halt_trap", pkt_trap, 0);
    check("halt_core_rst_n", core_rst_n, 1);
    step;
    check("halt_hold", pkt_valid, 1);
    pkt_ready = 1'b1;
    step;
    pkt_ready = 1'b0;
    check("halt_clear", pkt_valid, 0);
    push(1'b0, 32'h13);
    do_instr(32'h13, 1'b0, 1'b0, 1, 0);
    // back-pressure on the packet channel
    push(1'b0, 32'hA);
    push(1'b0, 32'hB);
    do_instr(32'hA, 1'b0, 1'b0, 2, 5);
    do_instr(32'hB, 1'b0, 1'b0, 3, 0);
    // stray retirement
    retire_valid = 1'b1;
    step;
    retire_valid = 1'b0;
    check("seq_err_set", seq_err, 1);
    step;
    step;
    check("seq_err_sticky", seq_err, 1);
    push(1'b0, 32'h33);
    do_instr(32'h33, 1'b0, 1'b0, 4, 0);
    check("seq_err_still", seq_err, 1);
    // reset while an instruction is in flight
    push(1'b0, 32'h44);
    push(1'b0, 32'h55);
    for (int i = 0; i < 20 && !core_instr_valid; i++) step;
    core_instr_ready = 1'b1;
    step;
    core_instr_ready = 1'b0;
    rst_n = 1'b0;
    step;
    check("mid_rst_core_rst_n", core_rst_n, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_issue", core_instr_valid, 0);
    check("mid_rst_instr", core_instr, 0);
    check("mid_rst_pkt_valid", pkt_valid, 0);
    check("mid_rst_pkt_order", pkt_order, 0);
    check("mid_rst_pkt_trap", pkt_trap, 0);
    check("mid_rst_pkt_halt", pkt_halt, 0);
    check("mid_rst_seq_err", seq_err, 0);
    rst_n = 1'b1;
    step;
    step;
    step;
    check("fifo_empty_issue", core_instr_valid, 0);
    check("fifo_empty_pkt", pkt_valid, 0);
    push(1'b0, 32'h66);
    check("latency_idle", core_instr_valid, 0);
    step;
    check("latency_issue", core_instr_valid, 1);
    do_instr(32'h66, 1'b0, 1'b0, 1, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
